// File: rtl/encoder_arb_pkg.sv
// rtl/encoder_arb_pkg.sv - shared state type, defaults and counter sizing for the encoder arbiter
package encoder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int SLICE_W_DEF    = 25;
  localparam int NUM_SLICES_DEF = 64;

  // Width of a counter that spans one job's slices (never below one bit).
  function automatic int CNT_W(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/encoder_arb_picker.sv
// rtl/encoder_arb_picker.sv - one-hot winner select, round-robin or fixed priority (ENC_ARB_FIXED_PRIORITY_EN)
module encoder_arb_picker
  import encoder_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner
);

`ifdef ENC_ARB_FIXED_PRIORITY_EN

  // The previous winner has no influence when the lowest index always wins.
  logic unused_last;
  assign unused_last = ^last;

  // Isolate the lowest set bit of the request vector.
  assign winner = req & (~req + NUM_REQ'(1));

`else

  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan from the requester after the previous winner, wrapping around once.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/encoder_arbiter.sv
// rtl/encoder_arbiter.sv - shares one encoder among NUM_REQ requesters (ENC_ARB_FIXED_PRIORITY_EN selects fixed priority)
module encoder_arbiter
  import encoder_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*SLICE_W-1:0] reqIn,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         take,
  output logic [NUM_REQ-1:0]         outValid,
  output logic [SLICE_W-1:0]         out,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       encStart,
  output logic [SLICE_W-1:0]         encIn,
  input  logic                       encReady,
  input  logic                       encPutInput,
  input  logic                       encOutReady,
  input  logic [SLICE_W-1:0]         encOut
);

  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OUT_CNT_W = CNT_W(NUM_SLICES);
  localparam logic [OUT_CNT_W-1:0] LAST_SLICE = OUT_CNT_W'(NUM_SLICES - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   enc_start_q, enc_start_d;
  logic                   busy_q, busy_d;
  logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [IDX_W-1:0]       last_q;
  logic [NUM_REQ-1:0]     winner;
  logic                   issue;
  logic                   in_run;
  logic [SLICE_W-1:0]     enc_in_mux;

  // A new job is launched only from IDLE with a pending request and an idle encoder.
  assign issue = (state_q == IDLE) && (|req) && encReady;

  encoder_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .winner (winner)
  );

`ifdef ENC_ARB_FIXED_PRIORITY_EN

  assign last_q = '0;

`else

  logic [IDX_W-1:0] last_d;
  logic [IDX_W-1:0] winner_idx;

  // Binary index of the one-hot winner, for the round-robin pointer.
  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) winner_idx = IDX_W'(i);
    end
  end

  // The pointer moves only when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (issue) last_d = winner_idx;
  end

  // Round-robin pointer; resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

`endif

  // Job sequencing: grant, one start pulse, count results, pulse done, release.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    enc_start_d = 1'b0;
    out_cnt_d   = out_cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          grant_d     = winner;
          enc_start_d = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        state_d = RUN;
      end
      RUN: begin
        if (encOutReady) begin
          if (out_cnt_q == LAST_SLICE) begin
            done_d  = grant_q;
            state_d = DONE;
          end else begin
            out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
          end
        end
      end
      DONE: begin
        grant_d   = '0;
        out_cnt_d = '0;
        state_d   = IDLE;
      end
      default: begin
        grant_d   = '0;
        out_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and all registered outputs; rst drops everything back to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      enc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      enc_start_q <= enc_start_d;
      busy_q      <= busy_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign in_run = (state_q == RUN);

  // Select the granted requester's input slice.
  always_comb begin
    enc_in_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) enc_in_mux = reqIn[i*SLICE_W +: SLICE_W];
    end
  end

  // Data steering is live only in RUN so stray encoder strobes elsewhere are ignored.
  assign take     = in_run ? (grant_q & {NUM_REQ{encPutInput}}) : '0;
  assign encIn    = in_run ? enc_in_mux : '0;
  assign outValid = in_run ? (grant_q & {NUM_REQ{encOutReady}}) : '0;
  assign out      = in_run ? encOut : '0;

  assign grant    = grant_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign encStart = enc_start_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
// tb/tb_encoder_arbiter.sv - directed self-checking bench for encoder_arbiter (ENC_ARB_FIXED_PRIORITY_EN aware)
module tb_encoder_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int SLICE_W    = 25;
  localparam int NUM_SLICES = 64;
  localparam logic [SLICE_W-1:0] KEY = 25'h1A5A5A5;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*SLICE_W-1:0] reqIn;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         take;
  logic [NUM_REQ-1:0]         outValid;
  logic [SLICE_W-1:0]         out;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;
  logic                       encStart;
  logic [SLICE_W-1:0]         encIn;
  logic                       encReady;
  logic                       encPutInput;
  logic                       encOutReady;
  logic [SLICE_W-1:0]         encOut;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int d0, d1, dx, r;
  logic [SLICE_W-1:0] in_mem [NUM_SLICES];

  encoder_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .reqIn       (reqIn),
    .grant       (grant),
    .take        (take),
    .outValid    (outValid),
    .out         (out),
    .done        (done),
    .busy        (busy),
    .encStart    (encStart),
    .encIn       (encIn),
    .encReady    (encReady),
    .encPutInput (encPutInput),
    .encOutReady (encOutReady),
    .encOut      (encOut)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req_data(input int rq, input logic [SLICE_W-1:0] d);
    for (int i = 0; i < NUM_REQ; i++) begin
      reqIn[i*SLICE_W +: SLICE_W] = (i == rq) ? d : ~d;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},    64'(grant),    64'd0);
    chk({tag, "_take"},     64'(take),     64'd0);
    chk({tag, "_outvalid"}, 64'(outValid), 64'd0);
    chk({tag, "_out"},      64'(out),      64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_encstart"}, 64'(encStart), 64'd0);
    chk({tag, "_encin"},    64'(encIn),    64'd0);
  endtask

  task automatic wait_start(input logic [NUM_REQ-1:0] exp_g);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cyc();
      #4;
      if (encStart === 1'b1) seen = 1'b1;
    end
    chk("start_seen",     64'(seen),  64'd1);
    chk("grant_at_start", 64'(grant), 64'(exp_g));
    chk("busy_at_start",  64'(busy),  64'd1);
  endtask

  // Plays the encoder for one job; rst_at >= 0 aborts with a reset at that output slice.
  task automatic job_body(input int rq, input logic [SLICE_W-1:0] base,
                          input logic [NUM_REQ-1:0] drop_mask, input int rst_at,
                          output int done_cycle);
    logic [NUM_REQ-1:0] g;
    logic [SLICE_W-1:0] exp_s;
    g = NUM_REQ'(1) << rq;
    done_cycle = -1;
    encReady = 1'b0;
    for (int j = 0; j < NUM_SLICES; j++) begin
      cyc();
      encPutInput = 1'b1;
      exp_s = base + SLICE_W'(j);
      drive_req_data(rq, exp_s);
      #4;
      chk("take",      64'(take),     64'(g));
      chk("enc_in",    64'(encIn),    64'(exp_s));
      chk("start_low", 64'(encStart), 64'd0);
      in_mem[j] = encIn;
    end
    cyc();
    encPutInput = 1'b0;
    reqIn = '0;
    #4;
    chk("take_after", 64'(take), 64'd0);
    cyc();
    #4;
    for (int j = 0; j < NUM_SLICES; j++) begin
      cyc();
      if (j == rst_at) begin
        rst = 1'b1;
        encOutReady = 1'b1;
        encPutInput = 1'b1;
        encOut = 25'h0ABCDE;
        #4;
        chk_all_zero("rst_mid");
        return;
      end
      encOutReady = 1'b1;
      encOut = in_mem[j] ^ KEY;
      #4;
      exp_s = (base + SLICE_W'(j)) ^ KEY;
      chk("out_valid",   64'(outValid), 64'(g));
      chk("out_data",    64'(out),      64'(exp_s));
      chk("done_early",  64'(done),     64'd0);
    end
    cyc();
    encOutReady = 1'b0;
    encOut = '0;
    encReady = 1'b1;
    #4;
    chk("done_pulse",  64'(done),     64'(g));
    chk("out_valid_0", 64'(outValid), 64'd0);
    chk("grant_hold",  64'(grant),    64'(g));
    done_cycle = cycle;
    cyc();
    req = req & ~drop_mask;
    #4;
    chk("done_clear", 64'(done),  64'd0);
    chk("grant_free", 64'(grant), 64'd0);
    chk("busy_free",  64'(busy),  64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    reqIn = '0;
    encReady = 1'b1;
    encPutInput = 1'b0;
    encOutReady = 1'b0;
    encOut = '0;
    cyc();
    cyc();
    #4;
    chk_all_zero("reset");
    cyc();
    rst = 1'b0;
    #4;
    chk_all_zero("post_reset");

    // single requester 0 with ramp data
    cyc();
    req = 2'b01;
    #4;
    chk("grant_not_yet", 64'(grant), 64'd0);
    wait_start(2'b01);
    job_body(0, 25'd0, 2'b01, -1, d0);

    // both requesting from reset: 0 then 1
    cyc();
    rst = 1'b1;
    #4;
    cyc();
    rst = 1'b0;
    req = 2'b11;
    #4;
    wait_start(2'b01);
    job_body(0, 25'h100, 2'b01, -1, d0);
    wait_start(2'b10);
    job_body(1, 25'h200, 2'b10, -1, d1);
    chk("done_gap", 64'((d1 - d0) >= 66), 64'd1);

    // both held for four jobs
    cyc();
    req = 2'b11;
    #4;
    for (int k = 0; k < 4; k++) begin
`ifdef ENC_ARB_FIXED_PRIORITY_EN
      r = 0;
`else
      r = k % 2;
`endif
      wait_start(NUM_REQ'(1) << r);
      job_body(r, SLICE_W'(25'h1000 + k * 25'h100), (k == 3) ? 2'b11 : 2'b00, -1, dx);
    end

    // encoder not ready holds off the grant
    cyc();
    encReady = 1'b0;
    req = 2'b10;
    #4;
    for (int n = 0; n < 10; n++) begin
      cyc();
      #4;
      chk("nrdy_grant", 64'(grant),    64'd0);
      chk("nrdy_start", 64'(encStart), 64'd0);
    end
    cyc();
    encReady = 1'b1;
    #4;
    chk("rdy_rise_grant", 64'(grant), 64'd0);
    cyc();
    #4;
    chk("rdy_start", 64'(encStart), 64'd1);
    chk("rdy_grant", 64'(grant),    64'(2'b10));
    job_body(1, 25'h3000, 2'b10, -1, dx);

    // reset at output slice 30, then a fresh requester 1 job
    cyc();
    req = 2'b01;
    #4;
    wait_start(2'b01);
    job_body(0, 25'h4000, 2'b00, 30, dx);
    cyc();
    rst = 1'b0;
    encOutReady = 1'b0;
    encPutInput = 1'b0;
    encOut = '0;
    encReady = 1'b1;
    req = 2'b10;
    #4;
    chk("rst_no_done", 64'(done), 64'd0);
    chk("rst_idle",    64'(busy), 64'd0);
    wait_start(2'b10);
    job_body(1, 25'h5000, 2'b10, -1, dx);

    // spurious encoder strobes while idle
    for (int n = 0; n < 3; n++) begin
      cyc();
      encOutReady = 1'b1;
      encPutInput = 1'b1;
      encOut = 25'h155;
      #4;
      chk_all_zero("spurious");
    end
    chk("spurious_cnt", 64'(dut.out_cnt_q), 64'd0);
    cyc();
    encOutReady = 1'b0;
    encPutInput = 1'b0;
    encOut = '0;
    req = 2'b01;
    #4;
    wait_start(2'b01);
    job_body(0, 25'h6000, 2'b01, -1, dx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_arbiter.md
# encoder_arbiter

Sequencer that shares one `Encoder` instance among `NUM_REQ` requesters. It grants the encoder to one requester per job, issues the encoder `start` pulse, and steers `NUM_SLICES` input slices from the winner into the encoder. It then returns the encoder's output slices to that same requester. It sits between the requester blocks and the encoder top, and owns all of the encoder's handshake pins.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `SLICE_W`, 25: slice width.
- `NUM_SLICES`, 64: slices per job, in and out.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  requester i wants a job; held high until its `done[i]`.
- `reqIn`  in  NUM_REQ*SLICE_W  slice from requester i at bits [i*SLICE_W +: SLICE_W].
- `grant`  out  NUM_REQ  one-hot owner of the encoder; 0 when idle.
- `take`  out  NUM_REQ  slice i of `reqIn` is consumed at this edge.
- `outValid`  out  NUM_REQ  `out` holds a result slice for requester i.
- `out`  out  SLICE_W  result slice.
- `done`  out  NUM_REQ  one-cycle pulse after requester i's last result slice.
- `busy`  out  1  a job is in progress.
- `encStart`  out  1  start pulse to the encoder.
- `encIn`  out  SLICE_W  slice to the encoder.
- `encReady`, `encPutInput`, `encOutReady`  in  1  encoder status.
- `encOut`  in  SLICE_W  encoder result.

## Operation
Encoder contract (fixed):
- `encReady` is high when the encoder is idle.
- After a one-cycle `start`, `encPutInput` is high for exactly NUM_SLICES cycles and consumes `encIn` each cycle.
- Later, `encOutReady` is high for exactly NUM_SLICES cycles with `encOut` valid.

FSM states: IDLE, START, RUN, DONE.
- IDLE: if `|req && encReady`, register the winner into `grant` and go to START. Otherwise stay.
- START: `encStart`=1 for one cycle, then go to RUN.
- RUN, combinational steering:
  - `take = grant & {NUM_REQ{encPutInput}}`.
  - `encIn` = `reqIn` slice selected by `grant`.
  - `outValid = grant & {NUM_REQ{encOutReady}}`.
  - `out = encOut`.
- RUN, result counting: output counter `outCnt` (clog2(NUM_SLICES) bits) increments on each `encOutReady`. When `encOutReady && outCnt==NUM_SLICES-1`, go to DONE.
- DONE: `done = grant` for one cycle. Then clear `grant` and `outCnt` and go to IDLE.
- Arbitration is round-robin. Pointer `last` holds the index of the previous winner. The search starts at `last+1` and wraps modulo NUM_REQ. `last` is updated only when a grant is issued.
- `busy` = state ≠ IDLE.
- `grant`, `encStart`, `done` and `busy` are registered. `take`, `encIn`, `outValid` and `out` are combinational. `encIn`, `out`, `take` and `outValid` are zero outside RUN.

Boundary conditions:
- `req[i]` dropped mid-job: protocol violation. The job still completes and `done[i]` still pulses.
- A request arriving while not in IDLE waits. A request seen during DONE is arbitrated in the following IDLE cycle.
- `encReady` low in IDLE: wait with `grant`=0.
- `encPutInput` or `encOutReady` asserted in IDLE or START: ignored, no `take` and no `outValid`.
- `outCnt` wraps only via the DONE clear. It never wraps inside RUN.
- `rst` mid-job: everything returns to IDLE immediately, and the encoder must be reset on the same `rst`.

Reset values:
- All outputs are 0 and the state is IDLE.
- `outCnt` = 0.
- `last` = NUM_REQ-1, so requester 0 wins first.

## Timing
- `req` sampled high at edge k: `grant` is valid after edge k, and `encStart` is high in cycle k+1.
- Result path adds zero cycles: `out`/`outValid` follow `encOut`/`encOutReady` in the same cycle.
- `done` is high in the cycle after the last `outValid`. The next `grant` can appear no earlier than 2 cycles after the `done` cycle.
- Overhead per job: 3 cycles beyond the encoder's own latency.

## Configuration
- `ENC_ARB_FIXED_PRIORITY_EN` defined: fixed priority. The lowest requesting index always wins and the `last` register is not built.
- Undefined (default): round-robin as described above.

## Structure
- Package `encoder_arb_pkg` holds:
  - the state enum {IDLE, START, RUN, DONE};
  - the defaults for SLICE_W and NUM_SLICES;
  - the CNT_W function (clog2(NUM_SLICES)).
- Sub-module `encoder_arb_picker`: a combinational one-hot winner selector. It takes `req` and `last` and produces the one-hot winner. The `ENC_ARB_FIXED_PRIORITY_EN` switch lives inside it.

## Test plan
- Single `req`=2'b01 with ramp data 0..63: one `encStart`; 64 `take[0]`; 64 `outValid[0]` matching the encoder model; `done`=2'b01 once.
- `req`=2'b11 from reset: requester 0 is served first, then requester 1. `grant` order is 01,10 and the two `done` pulses are ≥66 cycles apart.
- Both requesters held high for 4 jobs: grant alternates 01,10,01,10. With `ENC_ARB_FIXED_PRIORITY_EN`, grant stays 01 for every job.
- `req[1]` high while `encReady`=0 for 10 cycles: `grant` stays 0 and `encStart` stays low. `encStart` is issued the cycle after `encReady` rises.
- `rst` pulsed at output slice 30: all outputs are 0 next cycle and no `done` is issued. After release, a new `req[1]` wins and completes all 64 slices.
- Spurious `encOutReady` in IDLE: `outValid` stays 0 and `outCnt` stays 0.
